rs_ff: RTL and testbench

Clocked set/reset flip-flop used as the latching element for photonic switch control. It samples asynchronous set (`S`) and clear (`R`) requests, synchronizes and deglitches them, and holds the resulting state on `out` until the opposite request arrives. Downstream switch drivers use `out` as a stable level.

---
 rtl/rs_ff_if.sv | 20 ++
 rtl/rs_ff.sv | 95 +++++++++
 tb/tb_rs_ff.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rs_ff_if.sv
// Request/status bundle for the rs_ff latch.
// master drives S/R; slave returns out, out_n, conflict, changed.
interface rs_ff_if;
  logic S;
  logic R;
  logic out;
  logic out_n;
  logic conflict;
  logic changed;

  modport master (
    output S, R,
    input  out, out_n, conflict, changed
  );

  modport slave (
    input  S, R,
    output out, out_n, conflict, changed
  );
endinterface

// File: rtl/rs_ff.sv
// Deglitched set/reset latch: sync chain + stability filter per input.
// Ports: clk, reset (async, active-low), bus (rs_ff_if.slave).
module rs_ff #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter int   PRIORITY    = 0,
  parameter logic RESET_VALUE = 1'b0
) (
  input logic   clk,
  input logic   reset,
  rs_ff_if.slave bus
);

  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

  logic       ys, yr;
  logic       qs, qr;
  logic       qs_nxt, qr_nxt;
  logic       hit_s, hit_r;
  logic [3:0] cnt_s, cnt_r;
  logic       out_q, out_nxt;
  logic       conf_q, chg_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ys = bus.S;
      assign yr = bus.R;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs, cr;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cs <= '0;
          cr <= '0;
        end else begin
          cs <= (cs << 1) | SYNC_STAGES'(bus.S);
          cr <= (cr << 1) | SYNC_STAGES'(bus.R);
        end
      end

      assign ys = cs[SYNC_STAGES-1];
      assign yr = cr[SYNC_STAGES-1];
    end
  endgenerate

  // A counter tracks how many edges the synced level has
  // disagreed with the qualified one; the last such edge accepts.
  assign hit_s  = (ys != qs) && (cnt_s == LAST);
  assign hit_r  = (yr != qr) && (cnt_r == LAST);
  assign qs_nxt = hit_s ? ys : qs;
  assign qr_nxt = hit_r ? yr : qr;

  // Resolve on the incoming qualified levels so out moves
  // on the same edge that qualifies the request.
  always_comb begin
    out_nxt = out_q;
    unique case (1'b1)
      qs_nxt && !qr_nxt: out_nxt = 1'b1;
      !qs_nxt && qr_nxt: out_nxt = 1'b0;
      qs_nxt && qr_nxt && (PRIORITY == 1):
        out_nxt = 1'b1;
      qs_nxt && qr_nxt && (PRIORITY == 2):
        out_nxt = 1'b0;
      default: out_nxt = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qs     <= 1'b0;
      qr     <= 1'b0;
      cnt_s  <= '0;
      cnt_r  <= '0;
      out_q  <= RESET_VALUE;
      conf_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      qs <= qs_nxt;
      qr <= qr_nxt;
      if (ys == qs || hit_s) cnt_s <= '0;
      else                   cnt_s <= cnt_s + 4'd1;
      if (yr == qr || hit_r) cnt_r <= '0;
      else                   cnt_r <= cnt_r + 4'd1;
      out_q  <= out_nxt;
      conf_q <= qs_nxt & qr_nxt;
      chg_q  <= out_nxt ^ out_q;
    end
  end

  assign bus.out      = out_q;
  assign bus.out_n    = ~out_q;
  assign bus.conflict = conf_q;
  assign bus.changed  = chg_q;

endmodule

// File: tb/tb_rs_ff.sv
// Scoreboard bench for rs_ff across several parameter sets.
// History-window reference model; monitor pops per negedge.
module tb_rs_ff;

  localparam int NI = 5;
  localparam int SS [NI] = '{2, 0, 0, 1, 3};
  localparam int FL [NI] = '{1, 1, 4, 3, 2};
  localparam int PR [NI] = '{0, 1, 2, 0, 2};
  localparam bit RV [NI] = '{0, 0, 1, 1, 0};

  typedef struct packed {
    bit o;
    bit c;
    bit ch;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic s_in  = 1'b0;
  logic r_in  = 1'b0;

  logic [NI-1:0] o_out, o_outn, o_conf, o_chg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rs_ff_if bus ();
    assign bus.S = s_in;
    assign bus.R = r_in;
    rs_ff #(
      .SYNC_STAGES (SS[g]),
      .FILTER_LEN  (FL[g]),
      .PRIORITY    (PR[g]),
      .RESET_VALUE (RV[g])
    ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
    );
    assign o_out[g]  = bus.out;
    assign o_outn[g] = bus.out_n;
    assign o_conf[g] = bus.conflict;
    assign o_chg[g]  = bus.changed;
  end

  // Reference model: raw input history since reset.
  bit   hs [NI][$];
  bit   hr [NI][$];
  bit   mqs  [NI];
  bit   mqr  [NI];
  bit   mout [NI];
  exp_t eq [NI][$];

  // Synced level at edge n equals the input seen at edge
  // n-SYNC (0 before that). A level is accepted once the last
  // FILTER edges all show the opposite of the held level.
  function automatic bit qual(int i, bit is_r, bit q);
    int n;
    int idx;
    bit y;
    n = is_r ? hr[i].size() : hs[i].size();
    if (n < FL[i]) return q;
    for (int k = 0; k < FL[i]; k++) begin
      idx = n - 1 - k - SS[i];
      if (idx < 0) y = 1'b0;
      else y = is_r ? hr[i][idx] : hs[i][idx];
      if (y == q) return q;
    end
    return !q;
  endfunction

  function automatic bit resolve(int i, bit s, bit r, bit cur);
    if (s && !r) return 1'b1;
    if (!s && r) return 1'b0;
    if (s && r && PR[i] == 1) return 1'b1;
    if (s && r && PR[i] == 2) return 1'b0;
    return cur;
  endfunction

  always @(posedge clk) begin
    bit   ns, nr, no;
    exp_t e;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        hs[i].delete();
        hr[i].delete();
        mqs[i]  = 1'b0;
        mqr[i]  = 1'b0;
        mout[i] = RV[i];
        e = '{o: RV[i], c: 1'b0, ch: 1'b0};
      end else begin
        hs[i].push_back(s_in);
        hr[i].push_back(r_in);
        ns = qual(i, 1'b0, mqs[i]);
        nr = qual(i, 1'b1, mqr[i]);
        no = resolve(i, ns, nr, mout[i]);
        e = '{o: no, c: ns & nr, ch: no != mout[i]};
        mqs[i]  = ns;
        mqr[i]  = nr;
        mout[i] = no;
      end
      eq[i].push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (eq[i].size() > 0) begin
        e = eq[i].pop_front();
        checks++;
        if ({o_out[i], o_outn[i], o_conf[i], o_chg[i]} !==
            {e.o, ~e.o, e.c, e.ch}) begin
          failures++;
          $display("FAIL sb inst=%0d cyc=%0d got=%b%b%b%b want=%b%b%b%b",
                   i, cyc, o_out[i], o_outn[i], o_conf[i], o_chg[i],
                   e.o, ~e.o, e.c, e.ch);
        end
      end
    end
  end

  task automatic chk_rst(string nm);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({o_out[i], o_outn[i], o_conf[i], o_chg[i]} !==
          {RV[i], ~RV[i], 2'b00}) begin
        failures++;
        $display("FAIL %s inst=%0d got=%b%b%b%b want=%b%b00",
                 nm, i, o_out[i], o_outn[i], o_conf[i], o_chg[i],
                 RV[i], ~RV[i]);
      end
    end
  endtask

  task automatic drive(bit s, bit r, int n);
    s_in = s;
    r_in = r;
    repeat (n) @(negedge clk);
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_rst("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2 chk_rst("rst_now");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    drive(0, 0, 6);

    drive(1, 0, 1);
    drive(0, 0, 8);

    drive(1, 0, 8);
    drive(1, 1, 8);
    drive(1, 0, 8);
    drive(0, 0, 8);
    drive(0, 1, 8);
    drive(1, 1, 8);
    drive(1, 0, 8);
    drive(1, 1, 8);
    drive(0, 1, 8);
    drive(0, 0, 8);

    drive(1, 1, 8);
    drive(0, 1, 8);
    drive(0, 0, 8);

    for (int len = 1; len <= 5; len++) begin
      drive(1, 0, len);
      drive(0, 0, 8);
      drive(0, 1, 8);
      drive(0, 0, 8);
    end

    drive(1, 0, 1);
    async_rst();
    drive(1, 0, 10);
    drive(0, 0, 4);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) async_rst();
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            $urandom_range(1, 6));
    end

    drive(0, 0, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
